// File: rtl/uart_word_bridge.sv
// Byte-to-word bridge between a UART byte stream and a 32-bit word interpreter.
// RX bytes are packed little-endian into a small word FIFO; TX words are serialized LSB first.
module uart_word_bridge #(
    parameter int FIFO_DEPTH   = 4,
    parameter int BYTE_TIMEOUT = 360
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_byte_valid,
    input  logic [7:0]  rx_byte,
    output logic        tx_byte_valid,
    output logic [7:0]  tx_byte,
    input  logic        tx_byte_ready,
    output logic        uart_rx_empty,
    output logic        uart_tx_empty,
    input  logic        uart_read,
    input  logic        uart_write,
    output logic        uart_response,
    output logic [31:0] uart_read_data,
    input  logic [31:0] uart_write_data,
    output logic        rx_overflow
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = $clog2(BYTE_TIMEOUT + 1);
    localparam logic [CW-1:0] DEPTH_C      = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TIMEOUT_M1_C = TW'(BYTE_TIMEOUT - 1);

    typedef enum logic [1:0] {READ_IDLE, READ_RESP, READ_WAIT_LOW} rd_state_e;
    typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;

    // RX assembly state
    logic [1:0]    rx_idx_q, rx_idx_d;
    logic [23:0]   rx_part_q, rx_part_d;
    logic [TW-1:0] idle_q, idle_d;
    logic          ovf_q, ovf_d;

    // word FIFO
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push, pop, full;
    logic [31:0]   push_word;

    // read handshake
    rd_state_e     rd_state_q, rd_state_d;
    logic [31:0]   rdata_q, rdata_d;

    // TX serializer
    tx_state_e     tx_state_q, tx_state_d;
    logic [1:0]    tx_idx_q, tx_idx_d;
    logic [31:0]   tx_word_q, tx_word_d;

    assign full      = (cnt_q == DEPTH_C);
    assign pop       = (rd_state_q == READ_IDLE) && uart_read && (cnt_q != '0);
    assign push_word = {rx_byte, rx_part_q};

    // A pop in the same cycle frees the slot, so a full FIFO can still take the word.
    always_comb begin
        rx_idx_d  = rx_idx_q;
        rx_part_d = rx_part_q;
        idle_d    = idle_q;
        ovf_d     = ovf_q;
        push      = 1'b0;
        if (rx_byte_valid) begin
            idle_d   = '0;
            rx_idx_d = rx_idx_q + 2'd1;
            case (rx_idx_q)
                2'd0: rx_part_d[7:0]   = rx_byte;
                2'd1: rx_part_d[15:8]  = rx_byte;
                2'd2: rx_part_d[23:16] = rx_byte;
                default: begin
                    if (!full || pop) push = 1'b1;
                    else              ovf_d = 1'b1;
                end
            endcase
        end else if (rx_idx_q != 2'd0) begin
            if (idle_q == TIMEOUT_M1_C) begin
                idle_d   = '0;
                rx_idx_d = 2'd0;
            end else begin
                idle_d = idle_q + TW'(1);
            end
        end
    end

    always_comb begin
        wptr_d = wptr_q + AW'(push);
        rptr_d = rptr_q + AW'(pop);
        cnt_d  = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        case (rd_state_q)
            READ_IDLE: begin
                if (pop) begin
                    rdata_d    = mem_q[rptr_q];
                    rd_state_d = READ_RESP;
                end
            end
            READ_RESP:     rd_state_d = READ_WAIT_LOW;
            READ_WAIT_LOW: if (!uart_read) rd_state_d = READ_IDLE;
            default:       rd_state_d = READ_IDLE;
        endcase
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_idx_d   = tx_idx_q;
        tx_word_d  = tx_word_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (uart_write) begin
                    tx_word_d  = uart_write_data;
                    tx_idx_d   = 2'd0;
                    tx_state_d = TX_SEND;
                end
            end
            TX_SEND: begin
                if (tx_byte_ready) begin
                    tx_idx_d = tx_idx_q + 2'd1;
                    if (tx_idx_q == 2'd3) tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_idx_q   <= 2'd0;
            rx_part_q  <= '0;
            idle_q     <= '0;
            ovf_q      <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            rd_state_q <= READ_IDLE;
            rdata_q    <= '0;
            tx_state_q <= TX_IDLE;
            tx_idx_q   <= 2'd0;
            tx_word_q  <= '0;
        end else begin
            rx_idx_q   <= rx_idx_d;
            rx_part_q  <= rx_part_d;
            idle_q     <= idle_d;
            ovf_q      <= ovf_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            rd_state_q <= rd_state_d;
            rdata_q    <= rdata_d;
            tx_state_q <= tx_state_d;
            tx_idx_q   <= tx_idx_d;
            tx_word_q  <= tx_word_d;
        end
    end

    // Storage needs no reset: occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (!reset && push) mem_q[wptr_q] <= push_word;
    end

    always_comb begin
        tx_byte = 8'h00;
        if (tx_state_q == TX_SEND) begin
            case (tx_idx_q)
                2'd0:    tx_byte = tx_word_q[7:0];
                2'd1:    tx_byte = tx_word_q[15:8];
                2'd2:    tx_byte = tx_word_q[23:16];
                default: tx_byte = tx_word_q[31:24];
            endcase
        end
    end

    assign tx_byte_valid  = (tx_state_q == TX_SEND);
    assign uart_tx_empty  = (tx_state_q == TX_IDLE);
    assign uart_rx_empty  = (cnt_q == '0);
    assign uart_response  = (rd_state_q == READ_RESP);
    assign uart_read_data = rdata_q;
    assign rx_overflow    = ovf_q;

endmodule

// File: tb/tb_uart_word_bridge.sv
// Directed bench for uart_word_bridge: drivers queue expected words/bytes,
// free-running monitors pop and compare whenever the DUT responds.
module tb_uart_word_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_byte_valid = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        tx_byte_valid;
    logic [7:0]  tx_byte;
    logic        tx_byte_ready = 1'b0;
    logic        uart_rx_empty, uart_tx_empty;
    logic        uart_read = 1'b0;
    logic        uart_write = 1'b0;
    logic        uart_response;
    logic [31:0] uart_read_data;
    logic [31:0] uart_write_data = 32'h0;
    logic        rx_overflow;

    int total = 0;
    int bad = 0;
    int resp_cnt = 0;
    int tx_cnt = 0;
    logic [31:0] rd_q[$];
    logic [7:0]  tx_q[$];
    bit rdy_en = 1'b0;
    int rdy_ph = 0;

    always #5 clk = ~clk;

    uart_word_bridge #(.FIFO_DEPTH(4), .BYTE_TIMEOUT(360)) dut (
        .clk(clk), .reset(reset),
        .rx_byte_valid(rx_byte_valid), .rx_byte(rx_byte),
        .tx_byte_valid(tx_byte_valid), .tx_byte(tx_byte), .tx_byte_ready(tx_byte_ready),
        .uart_rx_empty(uart_rx_empty), .uart_tx_empty(uart_tx_empty),
        .uart_read(uart_read), .uart_write(uart_write),
        .uart_response(uart_response), .uart_read_data(uart_read_data),
        .uart_write_data(uart_write_data), .rx_overflow(rx_overflow)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte_valid = 1'b1;
        rx_byte = b;
        step();
        rx_byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
    endtask

    task automatic do_read(input logic [31:0] exp);
        int n;
        rd_q.push_back(exp);
        n = resp_cnt;
        uart_read = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (resp_cnt != n) break;
        end
        total++;
        if (resp_cnt == n) begin
            bad++;
            $display("FAIL read_timeout: got no response expected word %h", exp);
            void'(rd_q.pop_back());
        end
        uart_read = 1'b0;
        step(2);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tx_valid"}, 32'(tx_byte_valid), 32'd0);
        chk({tag, "_tx_byte"}, 32'(tx_byte), 32'd0);
        chk({tag, "_response"}, 32'(uart_response), 32'd0);
        chk({tag, "_read_data"}, uart_read_data, 32'd0);
        chk({tag, "_rx_empty"}, 32'(uart_rx_empty), 32'd1);
        chk({tag, "_tx_empty"}, 32'(uart_tx_empty), 32'd1);
        chk({tag, "_overflow"}, 32'(rx_overflow), 32'd0);
    endtask

    // Monitor: read responses and accepted TX bytes against the scoreboard queues.
    initial begin
        logic [31:0] ew;
        logic [7:0]  eb;
        bit prev_resp;
        prev_resp = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && uart_response) begin
                resp_cnt++;
                total++;
                if (prev_resp) begin
                    bad++;
                    $display("FAIL resp_pulse_width: got response high 2 cycles expected 1");
                end else if (rd_q.size() == 0) begin
                    bad++;
                    $display("FAIL rd_unexpected: got %h expected no response", uart_read_data);
                end else begin
                    ew = rd_q.pop_front();
                    if (uart_read_data !== ew) begin
                        bad++;
                        $display("FAIL rd_word: got %h expected %h", uart_read_data, ew);
                    end
                end
            end
            prev_resp = !reset && uart_response;
            if (!reset && tx_byte_valid && tx_byte_ready) begin
                tx_cnt++;
                total++;
                if (tx_q.size() == 0) begin
                    bad++;
                    $display("FAIL tx_unexpected: got %h expected no byte", tx_byte);
                end else begin
                    eb = tx_q.pop_front();
                    if (tx_byte !== eb) begin
                        bad++;
                        $display("FAIL tx_byte: got %h expected %h", tx_byte, eb);
                    end
                end
            end
        end
    end

    // Transmitter model: ready low three cycles, then high one cycle.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rdy_en) begin
                rdy_ph = (rdy_ph + 1) % 4;
                tx_byte_ready = (rdy_ph == 0);
            end else begin
                rdy_ph = 0;
                tx_byte_ready = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        step(3);
        chk_reset_outputs("rst");
        reset = 1'b0;
        step(2);

        // RX assembly and single read
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        chk("rx_not_empty", 32'(uart_rx_empty), 32'd0);
        do_read(32'h12345678);
        chk("rx_empty_after", 32'(uart_rx_empty), 32'd1);
        chk("read_data_hold", uart_read_data, 32'h12345678);

        // held read pops exactly one word
        send_word(32'h11223344);
        send_word(32'h55667788);
        rd_q.push_back(32'h11223344);
        n = resp_cnt;
        uart_read = 1'b1;
        step(10);
        chk("held_one_resp", 32'(resp_cnt - n), 32'd1);
        chk("held_one_left", 32'(uart_rx_empty), 32'd0);
        uart_read = 1'b0;
        step(2);
        do_read(32'h55667788);
        chk("held_drained", 32'(uart_rx_empty), 32'd1);

        // overflow: fifth word dropped
        send_word(32'hA0000001);
        send_word(32'hA0000002);
        send_word(32'hA0000003);
        send_word(32'hA0000004);
        chk("ovf_at_full", 32'(rx_overflow), 32'd0);
        send_word(32'hA0000005);
        chk("ovf_set", 32'(rx_overflow), 32'd1);
        do_read(32'hA0000001);
        do_read(32'hA0000002);
        do_read(32'hA0000003);
        do_read(32'hA0000004);
        chk("ovf_drained", 32'(uart_rx_empty), 32'd1);
        chk("ovf_sticky", 32'(rx_overflow), 32'd1);

        // partial word timeout
        send_byte(8'h01); send_byte(8'h02);
        step(361);
        chk("timeout_nothing_pushed", 32'(uart_rx_empty), 32'd1);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        do_read(32'hDDCCBBAA);
        chk("timeout_one_word", 32'(uart_rx_empty), 32'd1);

        // TX serialization, second write mid-send ignored
        tx_q.push_back(8'hBE); tx_q.push_back(8'hBA);
        tx_q.push_back(8'hFE); tx_q.push_back(8'hCA);
        n = tx_cnt;
        uart_write_data = 32'hCAFEBABE;
        uart_write = 1'b1;
        rdy_en = 1'b1;
        step();
        uart_write = 1'b0;
        chk("tx_busy", 32'(uart_tx_empty), 32'd0);
        chk("tx_valid", 32'(tx_byte_valid), 32'd1);
        chk("tx_first_byte", 32'(tx_byte), 32'hBE);
        step(5);
        uart_write_data = 32'h01020304;
        uart_write = 1'b1;
        step();
        uart_write = 1'b0;
        for (int i = 0; i < 100 && !uart_tx_empty; i++) step();
        chk("tx_done", 32'(uart_tx_empty), 32'd1);
        step(6);
        chk("tx_byte_count", 32'(tx_cnt - n), 32'd4);
        chk("tx_idle_valid", 32'(tx_byte_valid), 32'd0);
        rdy_en = 1'b0;
        step(2);

        // reset mid-word and mid-transmission
        send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
        tx_q.push_back(8'h11);
        n = tx_cnt;
        uart_write_data = 32'h44332211;
        uart_write = 1'b1;
        rdy_en = 1'b1;
        step();
        uart_write = 1'b0;
        for (int i = 0; i < 20 && tx_cnt == n; i++) step();
        chk("rst_tx_byte0_sent", 32'(tx_cnt - n), 32'd1);
        chk("rst_tx_on_byte1", 32'(tx_byte), 32'h22);
        rdy_en = 1'b0;
        reset = 1'b1;
        step(2);
        chk_reset_outputs("midrst");
        reset = 1'b0;
        step(6);
        chk("post_rst_tx_valid", 32'(tx_byte_valid), 32'd0);
        chk("post_rst_tx_empty", 32'(uart_tx_empty), 32'd1);
        send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
        do_read(32'hD4C3B2A1);
        chk("post_rst_drained", 32'(uart_rx_empty), 32'd1);
        chk("rd_queue_empty", 32'(rd_q.size()), 32'd0);
        chk("tx_queue_empty", 32'(tx_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
